// File: rtl/btn_debounce_bank_pkg.sv
// Shared defaults and width helper for the button debounce bank.
package btn_pkg;

    localparam int unsigned DEF_TICK_DIV     = 32'd10000;
    localparam int unsigned DEF_STABLE_TICKS = 32'd4;
    localparam int unsigned DEF_REPEAT_DELAY = 32'd50;
    localparam int unsigned DEF_REPEAT_RATE  = 32'd10;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_bank_channel.sv
// One debounce channel: 2-flop synchroniser, tick-driven stability filter,
// edge pulses and (with BTN_DEBOUNCE_REPEAT_EN) auto-repeat on held presses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
`ifdef BTN_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned SW = cnt_w(STABLE_TICKS);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 32'd1);

    logic          r_sync1;
    logic          r_sync2;
    logic [SW-1:0] r_stab_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    logic [SW-1:0] w_stab_nxt;
    logic          w_level_nxt;
    logic          w_rise;
    logic          w_fall;
    logic          w_press_nxt;

    // Stability filter: a differing sample must persist STABLE_TICKS ticks.
    always_comb begin
        w_stab_nxt  = r_stab_cnt;
        w_level_nxt = r_level;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        if (i_tick) begin
            if (r_sync2 == r_level) begin
                w_stab_nxt = {SW{1'b0}};
            end else if (r_stab_cnt == STAB_LAST) begin
                w_level_nxt = r_sync2;
                w_stab_nxt  = {SW{1'b0}};
                w_rise      = r_sync2;
                w_fall      = ~r_sync2;
            end else begin
                w_stab_nxt = r_stab_cnt + SW'(1);
            end
        end else begin
            w_stab_nxt = r_stab_cnt;
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW = cnt_w(REP_MAX);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 32'd1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 32'd1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_rate;
    logic [RW-1:0] w_rep_cnt_nxt;
    logic          w_rep_rate_nxt;
    logic          w_rep_fire;

    // Repeat timer: first period is REPEAT_DELAY ticks, then REPEAT_RATE; a
    // release tick always wins so the two pulses never coincide.
    always_comb begin
        w_rep_cnt_nxt  = r_rep_cnt;
        w_rep_rate_nxt = r_rep_rate;
        w_rep_fire     = 1'b0;
        if (!r_level || w_fall) begin
            w_rep_cnt_nxt  = {RW{1'b0}};
            w_rep_rate_nxt = 1'b0;
        end else if (i_tick) begin
            if (r_rep_cnt == (r_rep_rate ? RATE_LAST : DELAY_LAST)) begin
                w_rep_fire     = 1'b1;
                w_rep_cnt_nxt  = {RW{1'b0}};
                w_rep_rate_nxt = 1'b1;
            end else begin
                w_rep_cnt_nxt = r_rep_cnt + RW'(1);
            end
        end else begin
            w_rep_cnt_nxt = r_rep_cnt;
        end
        w_press_nxt = w_rise | w_rep_fire;
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt  <= {RW{1'b0}};
            r_rep_rate <= 1'b0;
        end else begin
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_rep_rate <= w_rep_rate_nxt;
        end
    end
`else
    assign w_press_nxt = w_rise;
`endif

    // Synchroniser, filter state and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stab_cnt <= {SW{1'b0}};
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_stab_cnt <= w_stab_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_fall;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_debounce_bank.sv
// N_CH-channel button debouncer with a shared sample tick.
// Optional auto-repeat is built when BTN_DEBOUNCE_REPEAT_EN is defined.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int unsigned N_CH         = 32'd4,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    localparam int unsigned TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 32'd1);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running tick divider shared by every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= {TW{1'b0}};
        end else if (w_tick) begin
            r_tick_cnt <= {TW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel #(
            .STABLE_TICKS (STABLE_TICKS)
`ifdef BTN_DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_btn     (btn_in[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g])
        );
    end

endmodule
